// File: rtl/vga_pkg.sv
// Shared definitions for the VGA tile mapper: tracker state encoding,
// default raster/tile geometry and a width helper for parameterised ports.
package vga_pkg;

  localparam int DEF_WIDTH_VGA    = 640;
  localparam int DEF_HEIGHT_VGA   = 480;
  localparam int DEF_WIDTH_MEM    = 16;
  localparam int DEF_HEIGHT_MEM   = 12;
  localparam int DEF_WIDTH_BLOCK  = 40;
  localparam int DEF_HEIGHT_BLOCK = 40;

  // Raster positions arrive as 10-bit values, so nothing may map past 1024.
  localparam int POS_W     = 10;
  localparam int POS_LIMIT = 1024;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } map_state_e;

  // Bit width able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_axis_counter.sv
// One axis of the tile tracker: an offset that wraps every BLOCK steps and
// carries into a tile index that saturates at TILES-1. Once the tile index
// would have gone past its limit, 'over' stays set until the next clear.
module tile_axis_counter
  import vga_pkg::*;
#(
  parameter int BLOCK = DEF_WIDTH_BLOCK,
  parameter int TILES = DEF_WIDTH_MEM,
  parameter int OW    = clog2w(BLOCK),
  parameter int TW    = clog2w(TILES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [OW-1:0] offset,
  output logic [TW-1:0] tile,
  output logic          over
);

  localparam logic [OW-1:0] OFF_MAX  = OW'(BLOCK - 1);
  localparam logic [TW-1:0] TILE_MAX = TW'(TILES - 1);

  logic [OW-1:0] offset_q, offset_d;
  logic [TW-1:0] tile_q, tile_d;
  logic          over_q, over_d;

  // Next offset/tile: clear wins, otherwise a step advances with wrap/carry.
  always_comb begin
    offset_d = offset_q;
    tile_d   = tile_q;
    over_d   = over_q;
    if (clr) begin
      offset_d = '0;
      tile_d   = '0;
      over_d   = 1'b0;
    end else if (step) begin
      if (offset_q == OFF_MAX) begin
        offset_d = '0;
        if (tile_q == TILE_MAX) begin
          over_d = 1'b1;
        end else begin
          tile_d = tile_q + TW'(1);
        end
      end else begin
        offset_d = offset_q + OW'(1);
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      tile_q   <= '0;
      over_q   <= 1'b0;
    end else begin
      offset_q <= offset_d;
      tile_q   <= tile_d;
      over_q   <= over_d;
    end
  end

  assign offset = offset_q;
  assign tile   = tile_q;
  assign over   = over_q;

endmodule

// File: rtl/vga_tile_mapper.sv
// Maps the VGA controller's pixel position onto a tile grid by following the
// raster incrementally. Stage 1 is the tracker (FSM plus axis counters), stage
// 2 registers the mapped fields and the row-major tile address.
//
// state       | meaning
// ST_UNLOCKED | waiting for pixel (0,0); no mapped output is produced
// ST_LOCKED   | raster followed pixel by pixel; each strobe yields an output
module vga_tile_mapper
  import vga_pkg::*;
#(
  parameter int WIDTH_VGA    = DEF_WIDTH_VGA,
  parameter int HEIGHT_VGA   = DEF_HEIGHT_VGA,
  parameter int WIDTH_MEM    = DEF_WIDTH_MEM,
  parameter int HEIGHT_MEM   = DEF_HEIGHT_MEM,
  parameter int WIDTH_BLOCK  = DEF_WIDTH_BLOCK,
  parameter int HEIGHT_BLOCK = DEF_HEIGHT_BLOCK,
  localparam int CW  = clog2w(WIDTH_MEM),
  localparam int RW  = clog2w(HEIGHT_MEM),
  localparam int OXW = clog2w(WIDTH_BLOCK),
  localparam int OYW = clog2w(HEIGHT_BLOCK),
  localparam int AW  = clog2w(WIDTH_MEM * HEIGHT_MEM)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             posValid,
  input  logic [POS_W-1:0] widthVgaPos,
  input  logic [POS_W-1:0] heightVgaPos,
  output logic [CW-1:0]    widthMemPos,
  output logic [RW-1:0]    heightMemPos,
  output logic [OXW-1:0]   offsetX,
  output logic [OYW-1:0]   offsetY,
  output logic [AW-1:0]    memAddr,
  output logic             outValid,
  output logic             outOfRange,
  output logic             locked
);

  if (WIDTH_MEM * WIDTH_BLOCK > POS_LIMIT) begin : g_bad_width
    $error("vga_tile_mapper: WIDTH_MEM*WIDTH_BLOCK exceeds the 10-bit pixel range");
  end
  if (HEIGHT_MEM * HEIGHT_BLOCK > POS_LIMIT) begin : g_bad_height
    $error("vga_tile_mapper: HEIGHT_MEM*HEIGHT_BLOCK exceeds the 10-bit line range");
  end
  if (WIDTH_VGA > POS_LIMIT || HEIGHT_VGA > POS_LIMIT) begin : g_bad_raster
    $error("vga_tile_mapper: raster does not fit 10-bit positions");
  end
  if (WIDTH_BLOCK < 2 || HEIGHT_BLOCK < 2) begin : g_bad_block
    $error("vga_tile_mapper: tiles must be at least 2 pixels on each axis");
  end

  map_state_e       state_q, state_d;
  logic [POS_W-1:0] prev_x_q, prev_x_d;
  logic [POS_W-1:0] prev_y_q, prev_y_d;
  logic             s1_valid_q, s1_valid_d;

  logic [CW-1:0]    wmp_q, wmp_d;
  logic [RW-1:0]    hmp_q, hmp_d;
  logic [OXW-1:0]   offx_q, offx_d;
  logic [OYW-1:0]   offy_q, offy_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             ov_q, ov_d;
  logic             oor_q, oor_d;

  logic             col_clr, col_step, row_clr, row_step;
  logic             x_zero, y_zero, x_seq, y_seq, y_same;

  logic [OXW-1:0]   col_off;
  logic [CW-1:0]    col_tile;
  logic             col_over;
  logic [OYW-1:0]   row_off;
  logic [RW-1:0]    row_tile;
  logic             row_over;

  // Tracker decision: classify the strobed position against the previous one.
  always_comb begin
    state_d    = state_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    s1_valid_d = 1'b0;
    col_clr    = 1'b0;
    col_step   = 1'b0;
    row_clr    = 1'b0;
    row_step   = 1'b0;
    x_zero     = (widthVgaPos == '0);
    y_zero     = (heightVgaPos == '0);
    // Compared one bit wider so line 1023 is never mistaken for the line before 0.
    x_seq      = ({1'b0, widthVgaPos} == ({1'b0, prev_x_q} + (POS_W + 1)'(1)));
    y_seq      = ({1'b0, heightVgaPos} == ({1'b0, prev_y_q} + (POS_W + 1)'(1)));
    y_same     = (heightVgaPos == prev_y_q);
    if (posValid) begin
      prev_x_d = widthVgaPos;
      prev_y_d = heightVgaPos;
      case (state_q)
        ST_UNLOCKED: begin
          if (x_zero && y_zero) begin
            state_d    = ST_LOCKED;
            col_clr    = 1'b1;
            row_clr    = 1'b1;
            s1_valid_d = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (x_zero && y_seq) begin
            col_clr    = 1'b1;
            row_step   = 1'b1;
            s1_valid_d = 1'b1;
          end else if (x_zero && y_zero) begin
            col_clr    = 1'b1;
            row_clr    = 1'b1;
            s1_valid_d = 1'b1;
          end else if (x_seq && y_same) begin
            col_step   = 1'b1;
            s1_valid_d = 1'b1;
          end else begin
            state_d = ST_UNLOCKED;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  tile_axis_counter #(
    .BLOCK(WIDTH_BLOCK),
    .TILES(WIDTH_MEM),
    .OW   (OXW),
    .TW   (CW)
  ) u_col (
    .clk   (Clock),
    .rst   (Reset),
    .clr   (col_clr),
    .step  (col_step),
    .offset(col_off),
    .tile  (col_tile),
    .over  (col_over)
  );

  tile_axis_counter #(
    .BLOCK(HEIGHT_BLOCK),
    .TILES(HEIGHT_MEM),
    .OW   (OYW),
    .TW   (RW)
  ) u_row (
    .clk   (Clock),
    .rst   (Reset),
    .clr   (row_clr),
    .step  (row_step),
    .offset(row_off),
    .tile  (row_tile),
    .over  (row_over)
  );

  // Output stage: capture the tracker's view of the previous pixel plus its address.
  always_comb begin
    wmp_d  = col_tile;
    hmp_d  = row_tile;
    offx_d = col_off;
    offy_d = row_off;
    addr_d = AW'(row_tile) * AW'(WIDTH_MEM) + AW'(col_tile);
    oor_d  = col_over | row_over;
    ov_d   = s1_valid_q;
  end

  // All tracker and output-stage registers; Reset outranks any pixel strobe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_UNLOCKED;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      s1_valid_q <= 1'b0;
      wmp_q      <= '0;
      hmp_q      <= '0;
      offx_q     <= '0;
      offy_q     <= '0;
      addr_q     <= '0;
      ov_q       <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      s1_valid_q <= s1_valid_d;
      wmp_q      <= wmp_d;
      hmp_q      <= hmp_d;
      offx_q     <= offx_d;
      offy_q     <= offy_d;
      addr_q     <= addr_d;
      ov_q       <= ov_d;
      oor_q      <= oor_d;
    end
  end

  assign widthMemPos  = wmp_q;
  assign heightMemPos = hmp_q;
  assign offsetX      = offx_q;
  assign offsetY      = offy_q;
  assign memAddr      = addr_q;
  assign outValid     = ov_q;
  assign outOfRange   = oor_q;
  // Taken straight from the state register so a lost lock shows one cycle after the bad pixel.
  assign locked       = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_vga_tile_mapper.sv
// Directed bench for vga_tile_mapper. Two instances share one stimulus
// stream: the default 16x12 grid and a 10-column variant whose grid ends at
// x=400 on a 640-pixel line. Outputs are sampled 1 time unit after each
// rising edge; after step() returns, the visible outputs belong to the pixel
// driven two step() calls earlier.
module tb_vga_tile_mapper;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       posValid;
  logic [9:0] widthVgaPos;
  logic [9:0] heightVgaPos;

  logic [3:0] wmp, hmp;
  logic [5:0] ox, oy;
  logic [7:0] addr;
  logic       ov, oor, lk;

  logic [3:0] w_wmp, w_hmp;
  logic [5:0] w_ox, w_oy;
  logic [6:0] w_addr;
  logic       w_ov, w_oor, w_lk;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  vga_tile_mapper dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .posValid    (posValid),
    .widthVgaPos (widthVgaPos),
    .heightVgaPos(heightVgaPos),
    .widthMemPos (wmp),
    .heightMemPos(hmp),
    .offsetX     (ox),
    .offsetY     (oy),
    .memAddr     (addr),
    .outValid    (ov),
    .outOfRange  (oor),
    .locked      (lk)
  );

  vga_tile_mapper #(.WIDTH_MEM(10)) dut_w10 (
    .Clock       (Clock),
    .Reset       (Reset),
    .posValid    (posValid),
    .widthVgaPos (widthVgaPos),
    .heightVgaPos(heightVgaPos),
    .widthMemPos (w_wmp),
    .heightMemPos(w_hmp),
    .offsetX     (w_ox),
    .offsetY     (w_oy),
    .memAddr     (w_addr),
    .outValid    (w_ov),
    .outOfRange  (w_oor),
    .locked      (w_lk)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input int e_wmp, input int e_hmp,
                            input int e_ox, input int e_oy, input int e_addr, input int e_ov);
    chk({tag, ".col"},   32'(wmp),  e_wmp);
    chk({tag, ".row"},   32'(hmp),  e_hmp);
    chk({tag, ".offx"},  32'(ox),   e_ox);
    chk({tag, ".offy"},  32'(oy),   e_oy);
    chk({tag, ".addr"},  32'(addr), e_addr);
    chk({tag, ".valid"}, 32'(ov),   e_ov);
  endtask

  task automatic step(input logic r, input logic v, input int x, input int y);
    @(posedge Clock);
    #1;
    Reset        = r;
    posValid     = v;
    widthVgaPos  = x[9:0];
    heightVgaPos = y[9:0];
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int g;
    Reset        = 1'b1;
    posValid     = 1'b0;
    widthVgaPos  = '0;
    heightVgaPos = '0;

    // Reset state
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    check_main("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.oor", 32'(oor), 0);
    chk("reset.locked", 32'(lk), 0);
    chk("reset.w10_valid", 32'(w_ov), 0);

    // A non-origin pixel while unlocked must not lock or produce output
    step(1'b0, 1'b1, 5, 3);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    chk("nolock.valid", 32'(ov), 0);
    chk("nolock.locked", 32'(lk), 0);

    // Line 0, all 640 pixels, locking on (0,0)
    for (int i = 0; i < 643; i++) begin
      if (i < 640) step(1'b0, 1'b1, i, 0);
      else         step(1'b0, 1'b0, 0, 0);
      if (i == 1) begin
        chk("lock.locked", 32'(lk), 1);
        chk("lock.early_valid", 32'(ov), 0);
      end
      k = i - 2;
      if (k == 0)  check_main("px0_0", 0, 0, 0, 0, 0, 1);
      if (k == 39) check_main("px39_0", 0, 0, 39, 0, 0, 1);
      if (k == 40) check_main("px40_0", 1, 0, 0, 0, 1, 1);
      if (k == 399) begin
        chk("w10_px399.col", 32'(w_wmp), 9);
        chk("w10_px399.offx", 32'(w_ox), 39);
        chk("w10_px399.oor", 32'(w_oor), 0);
      end
      if (k == 400) begin
        chk("w10_px400.col", 32'(w_wmp), 9);
        chk("w10_px400.oor", 32'(w_oor), 1);
        chk("w10_px400.addr", 32'(w_addr), 9);
      end
      if (k == 639) begin
        check_main("px639_0", 15, 0, 39, 0, 15, 1);
        chk("px639_0.oor", 32'(oor), 0);
        chk("w10_px639.col", 32'(w_wmp), 9);
        chk("w10_px639.oor", 32'(w_oor), 1);
        chk("w10_px639.addr", 32'(w_addr), 9);
      end
      if (k == 640) chk("after_line0.valid", 32'(ov), 0);
    end

    // Lines 1..478 carry only their first two pixels; 160-cycle blanking after lines 1..3
    for (int y = 1; y < 479; y++) begin
      step(1'b0, 1'b1, 0, y);
      step(1'b0, 1'b1, 1, y);
      g = (y <= 3) ? 160 : 2;
      for (int j = 0; j < g; j++) begin
        step(1'b0, 1'b0, 0, 0);
        if (j == 1 && y == 2)   check_main("line2", 0, 0, 1, 2, 0, 1);
        if (j == 2 && y == 2)   chk("gap.valid", 32'(ov), 0);
        if (j == 159 && y == 3) chk("gap.locked", 32'(lk), 1);
        if (j == 1 && y == 39)  check_main("line39", 0, 0, 1, 39, 0, 1);
        if (j == 1 && y == 40)  check_main("line40", 0, 1, 1, 0, 16, 1);
        if (j == 1 && y == 478) check_main("line478", 0, 11, 1, 38, 176, 1);
      end
    end

    // Line 479 in full, ending on the last pixel of the frame
    for (int i = 0; i < 643; i++) begin
      if (i < 640) step(1'b0, 1'b1, i, 479);
      else         step(1'b0, 1'b0, 0, 0);
      k = i - 2;
      if (k == 0) check_main("px0_479", 0, 11, 0, 39, 176, 1);
      if (k == 639) begin
        check_main("px639_479", 15, 11, 39, 39, 191, 1);
        chk("px639_479.oor", 32'(oor), 0);
        chk("px639_479.locked", 32'(lk), 1);
        chk("w10_last.col", 32'(w_wmp), 9);
        chk("w10_last.row", 32'(w_hmp), 11);
        chk("w10_last.oor", 32'(w_oor), 1);
        chk("w10_last.addr", 32'(w_addr), 119);
      end
      if (k == 640) chk("after_frame.valid", 32'(ov), 0);
    end

    // New frame, then a raster jump (100,5) -> (300,5)
    step(1'b0, 1'b1, 0, 0);
    for (int y = 1; y <= 5; y++) step(1'b0, 1'b1, 0, y);
    for (int x = 1; x <= 100; x++) step(1'b0, 1'b1, x, 5);
    step(1'b0, 1'b1, 300, 5);
    step(1'b0, 1'b0, 0, 0);
    chk("jump.locked", 32'(lk), 0);
    check_main("px100_5", 2, 0, 20, 5, 2, 1);
    step(1'b0, 1'b0, 0, 0);
    chk("jump.valid", 32'(ov), 0);
    step(1'b0, 1'b1, 301, 5);
    chk("unlocked1.valid", 32'(ov), 0);
    step(1'b0, 1'b1, 302, 5);
    chk("unlocked2.valid", 32'(ov), 0);
    step(1'b0, 1'b1, 0, 6);
    chk("unlocked3.valid", 32'(ov), 0);
    step(1'b0, 1'b0, 0, 0);
    chk("unlocked4.valid", 32'(ov), 0);
    step(1'b0, 1'b0, 0, 0);
    chk("unlocked5.valid", 32'(ov), 0);
    chk("unlocked5.locked", 32'(lk), 0);
    step(1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    chk("relock.locked", 32'(lk), 1);
    chk("relock.early_valid", 32'(ov), 0);
    step(1'b0, 1'b0, 0, 0);
    check_main("relock", 0, 0, 0, 0, 0, 1);

    // Reset arriving together with pixel (200,200)
    for (int y = 1; y <= 200; y++) step(1'b0, 1'b1, 0, y);
    for (int x = 1; x < 200; x++) step(1'b0, 1'b1, x, 200);
    step(1'b1, 1'b1, 200, 200);
    check_main("px198_200", 4, 5, 38, 0, 84, 1);
    step(1'b0, 1'b0, 0, 0);
    check_main("reset_mid", 0, 0, 0, 0, 0, 0);
    chk("reset_mid.locked", 32'(lk), 0);
    chk("reset_mid.oor", 32'(oor), 0);
    step(1'b0, 1'b1, 201, 200);
    chk("flush1.valid", 32'(ov), 0);
    step(1'b0, 1'b1, 202, 200);
    chk("flush2.valid", 32'(ov), 0);
    step(1'b0, 1'b1, 0, 201);
    chk("flush3.valid", 32'(ov), 0);
    step(1'b0, 1'b1, 0, 0);
    chk("flush4.valid", 32'(ov), 0);
    step(1'b0, 1'b0, 0, 0);
    chk("flush5.valid", 32'(ov), 0);
    chk("relock2.locked", 32'(lk), 1);
    step(1'b0, 1'b0, 0, 0);
    check_main("relock2", 0, 0, 0, 0, 0, 1);

    // Reset outranks a simultaneous (0,0) strobe
    step(1'b1, 1'b1, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    chk("prio.locked", 32'(lk), 0);
    step(1'b0, 1'b0, 0, 0);
    chk("prio.valid", 32'(ov), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
